// File: rtl/hud_update_ctrl.sv
// HUD digit write scheduler: tracks per-drum hit counts and issues one
// renderer write per changed blob, started only during vertical blanking.
module hud_update_ctrl #(
   parameter int NUM_BLOBS    = 4,
   parameter int VBLANK_START = 768,
   parameter int MAX_DIGIT    = 9
) (
   input  logic                 vclock,
   input  logic                 reset_n,
   input  logic [NUM_BLOBS-1:0] hit,
   input  logic                 clear,
   input  logic [9:0]           vcount,
   output logic                 write,
   output logic [3:0]           num,
   output logic [3:0]           blob,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_WRITE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           count_q [NUM_BLOBS];
   logic [3:0]           count_d [NUM_BLOBS];
   logic [NUM_BLOBS-1:0] pending_q, pending_d;
   logic [3:0]           rr_ptr_q, rr_ptr_d;
   logic [3:0]           sel_q, sel_d;
   logic                 write_q, write_d;
   logic [3:0]           num_q, num_d;
   logic [3:0]           blob_q, blob_d;
   logic                 busy_q, busy_d;
   logic [3:0]           cur_count;
   logic                 in_vblank;

   // First pending blob at or after ptr, wrapping modulo NUM_BLOBS.
   function automatic logic [3:0] rr_select(input logic [NUM_BLOBS-1:0] pend,
                                            input logic [3:0] ptr);
      logic [3:0] pick;
      logic       found;
      int         idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_BLOBS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_BLOBS) idx = idx - NUM_BLOBS;
         if (!found && pend[idx]) begin
            found = 1'b1;
            pick  = 4'(idx);
         end
      end
      return pick;
   endfunction

   assign in_vblank = (vcount >= 10'(VBLANK_START));

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      sel_d     = sel_q;
      write_d   = 1'b0;
      num_d     = num_q;
      blob_d    = blob_q;
      pending_d = pending_q;
      cur_count = 4'd0;

      for (int i = 0; i < NUM_BLOBS; i++) begin
         count_d[i] = count_q[i];
         if (sel_q == 4'(i)) cur_count = count_q[i];
      end

      // Hits and clear always re-pend, so a write racing them never drops the newer value.
      for (int i = 0; i < NUM_BLOBS; i++) begin
         if (clear) begin
            count_d[i]   = 4'd0;
            pending_d[i] = 1'b1;
         end else if (hit[i]) begin
            count_d[i]   = (count_q[i] == 4'(MAX_DIGIT)) ? 4'd0 : count_q[i] + 4'd1;
            pending_d[i] = 1'b1;
         end else if (state_q == S_WRITE && sel_q == 4'(i)) begin
            pending_d[i] = 1'b0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (|pending_q && in_vblank) state_d = S_GRANT;
         end
         S_GRANT: begin
            sel_d   = rr_select(pending_q, rr_ptr_q);
            state_d = S_WRITE;
         end
         S_WRITE: begin
            write_d = 1'b1;
            blob_d  = sel_q;
            num_d   = cur_count;
            state_d = S_GAP;
         end
         S_GAP: begin
            rr_ptr_d = (sel_q == 4'(NUM_BLOBS - 1)) ? 4'd0 : sel_q + 4'd1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) || (|pending_d);
   end

   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pending_q <= '1;
         rr_ptr_q  <= 4'd0;
         sel_q     <= 4'd0;
         write_q   <= 1'b0;
         num_q     <= 4'd0;
         blob_q    <= 4'd0;
         busy_q    <= 1'b1;
         for (int i = 0; i < NUM_BLOBS; i++) count_q[i] <= 4'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         sel_q     <= sel_d;
         write_q   <= write_d;
         num_q     <= num_d;
         blob_q    <= blob_d;
         busy_q    <= busy_d;
         for (int i = 0; i < NUM_BLOBS; i++) count_q[i] <= count_d[i];
      end
   end

   assign write = write_q;
   assign num   = num_q;
   assign blob  = blob_q;
   assign busy  = busy_q;

endmodule
